nios2_jtag_ocimem_master: RTL and testbench



---
 rtl/nios2_jtag_ocimem_pkg.sv | 19 +
 rtl/nios2_jtag_ocimem_master_if.sv | 33 +++
 rtl/nios2_jtag_ocimem_wait_timer.sv | 30 +++
 rtl/nios2_jtag_ocimem_master.sv | 114 +++++++++++
 tb/tb_nios2_jtag_ocimem_master.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/nios2_jtag_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI memory engine.
// State enum, payload bit positions and the timeout read pattern.
package nios2_jtag_ocimem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } ocimem_state_t;

  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_RD_BIT    = 34;
  localparam int JDO_CLR_BIT   = 36;
  localparam int JDO_WDATA_LSB = 3;
  localparam int JDO_WDATA_MSB = 34;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/nios2_jtag_ocimem_master_if.sv
// Avalon-MM master bundle for the OCI memory engine.
// master: drives address/read/write/writedata/byteenable; slave: readdata/waitrequest.
interface nios2_jtag_ocimem_master_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W+1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    output avm_write,
    output avm_writedata,
    output avm_byteenable,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    input  avm_write,
    input  avm_writedata,
    input  avm_byteenable,
    output avm_readdata,
    output avm_waitrequest
  );
endinterface

// File: rtl/nios2_jtag_ocimem_wait_timer.sv
// 16-bit saturating wait-state counter with a limit compare.
// clear/inc control the count; expired flags the stall that reaches limit.
module nios2_jtag_ocimem_wait_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        inc,
  input  logic [15:0] limit,
  output logic        expired
);

  logic [15:0] count;
  logic [16:0] count_p1;

  assign count_p1 = {1'b0, count} + 17'd1;

  // Fires in the stall cycle that brings the count up to limit.
  assign expired = inc && (count_p1 >= {1'b0, limit});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count_p1[15:0];
    end
  end

endmodule

// File: rtl/nios2_jtag_ocimem_master.sv
// JTAG debug OCI memory engine: single-word Avalon reads/writes.
// Ports: clk/reset, jdo + strobes in, avm bus, MonDReg/monitor_* out.
module nios2_jtag_ocimem_master
  import nios2_jtag_ocimem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  nios2_jtag_ocimem_master_if.master avm,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error
);

  ocimem_state_t state, state_nxt;

  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [31:0]       wdata, wdata_nxt;
  logic [31:0]       mon_nxt;
  logic              err_nxt;
  logic              rd_q, wr_q;
  logic              any_stb;
  logic              busy;
  logic              expired;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37], jdo[35], jdo[2:0]};

  assign any_stb = take_action_ocimem_a
                 | take_action_ocimem_b
                 | take_no_action_ocimem_a;

  assign busy = (state != IDLE);

  nios2_jtag_ocimem_wait_timer u_timer (
    .clk     (clk),
    .rst     (reset),
    .clear   (!busy),
    .inc     (busy && avm.avm_waitrequest),
    .limit   (16'(TIMEOUT)),
    .expired (expired)
  );

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    wdata_nxt = wdata;
    mon_nxt   = MonDReg;
    err_nxt   = monitor_error;
    unique case (state)
      IDLE: begin
        if (take_action_ocimem_b) begin
          wdata_nxt = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
          state_nxt = WRITE;
        end else if (take_action_ocimem_a) begin
          addr_nxt = jdo[JDO_ADDR_LSB +: ADDR_W];
          if (jdo[JDO_CLR_BIT]) err_nxt = 1'b0;
          if (jdo[JDO_RD_BIT]) state_nxt = READ;
        end else if (take_no_action_ocimem_a) begin
          state_nxt = READ;
        end
      end
      READ, WRITE: begin
        // Overrun: strobes while busy are dropped and flagged.
        if (any_stb) err_nxt = 1'b0 | 1'b1;
        if (!avm.avm_waitrequest) begin
          if (state == READ) mon_nxt = avm.avm_readdata;
          addr_nxt  = addr + 1'b1;
          state_nxt = IDLE;
        end else if (expired) begin
          if (state == READ) mon_nxt = TIMEOUT_DATA;
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      wdata         <= '0;
      MonDReg       <= '0;
      monitor_error <= 1'b0;
      monitor_ready <= 1'b1;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
    end else begin
      state         <= state_nxt;
      addr          <= addr_nxt;
      wdata         <= wdata_nxt;
      MonDReg       <= mon_nxt;
      monitor_error <= err_nxt;
      monitor_ready <= (state_nxt == IDLE);
      rd_q          <= (state_nxt == READ);
      wr_q          <= (state_nxt == WRITE);
    end
  end

  assign avm.avm_address    = {addr, 2'b00};
  assign avm.avm_read       = rd_q;
  assign avm.avm_write      = wr_q;
  assign avm.avm_writedata  = wdata;
  assign avm.avm_byteenable = 4'hF;

endmodule

// File: tb/tb_nios2_jtag_ocimem_master.sv
// Self-checking bench for nios2_jtag_ocimem_master (TIMEOUT=8).
// Transaction-level model checked every cycle plus literal checks.
module tb_nios2_jtag_ocimem_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        sa = 1'b0;
  logic        sb = 1'b0;
  logic        sn = 1'b0;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  nios2_jtag_ocimem_master_if #(.ADDR_W(10)) bus ();

  nios2_jtag_ocimem_master #(.ADDR_W(10), .TIMEOUT(TMO)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (sa),
    .take_action_ocimem_b    (sb),
    .take_no_action_ocimem_a (sn),
    .avm                     (bus),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  // Model: 0 none, 1 read pending, 2 write pending.
  logic [1:0]  m_kind;
  logic [9:0]  m_addr;
  logic [31:0] m_mon;
  logic [31:0] m_wdata;
  logic        m_err;
  int          m_stalls;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_kind = 2'd0;
    m_addr = '0;
    m_mon = '0;
    m_wdata = '0;
    m_err = 1'b0;
    m_stalls = 0;
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
    end else if (m_kind == 2'd0) begin
      if (sb) begin
        m_wdata = jdo[34:3];
        m_kind = 2'd2;
        m_stalls = 0;
      end else if (sa) begin
        m_addr = jdo[26:17];
        if (jdo[36]) m_err = 1'b0;
        if (jdo[34]) begin
          m_kind = 2'd1;
          m_stalls = 0;
        end
      end else if (sn) begin
        m_kind = 2'd1;
        m_stalls = 0;
      end
    end else begin
      if (sa || sb || sn) m_err = 1'b1;
      if (!bus.avm_waitrequest) begin
        if (m_kind == 2'd1) m_mon = bus.avm_readdata;
        m_addr = m_addr + 10'd1;
        m_kind = 2'd0;
      end else begin
        m_stalls++;
        if (m_stalls == TMO) begin
          if (m_kind == 2'd1) m_mon = 32'hDEAD_BEEF;
          m_err = 1'b1;
          m_kind = 2'd0;
        end
      end
    end
  endtask

  task automatic cyc(input logic a, input logic b, input logic n,
                     input logic [37:0] j, input logic w);
    sa = a;
    sb = b;
    sn = n;
    jdo = j;
    bus.avm_waitrequest = w;
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [37:0] mk_a(input logic [9:0] ad,
                                       input logic rd, input logic clr);
    logic [37:0] j;
    j = '0;
    j[26:17] = ad;
    j[34] = rd;
    j[36] = clr;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("read", 32'(bus.avm_read), 32'(m_kind == 2'd1));
      chk("write", 32'(bus.avm_write), 32'(m_kind == 2'd2));
      chk("address", 32'(bus.avm_address), 32'({m_addr, 2'b00}));
      chk("ready", 32'(monitor_ready), 32'(m_kind == 2'd0));
      chk("error", 32'(monitor_error), 32'(m_err));
      chk("mondreg", MonDReg, m_mon);
      chk("byteen", 32'(bus.avm_byteenable), 32'h0000_000F);
      if (m_kind == 2'd2) chk("wdata", bus.avm_writedata, m_wdata);
    end
  end

  int n;

  initial begin
    model_reset();
    bus.avm_readdata = '0;
    bus.avm_waitrequest = 1'b0;
    cyc(0, 0, 0, '0, 0);
    cyc(0, 0, 0, '0, 0);
    chk("rst_ready", 32'(monitor_ready), 32'd1);
    chk("rst_error", 32'(monitor_error), 32'd0);
    chk("rst_mon", MonDReg, 32'h0);
    chk("rst_req", 32'({bus.avm_read, bus.avm_write}), 32'd0);
    chk("rst_addr", 32'(bus.avm_address), 32'h0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Zero-wait read at word 3.
    bus.avm_readdata = 32'h1234_5678;
    cyc(1, 0, 0, mk_a(10'h3, 1, 0), 0);
    chk("zw_read", 32'(bus.avm_read), 32'd1);
    chk("zw_addr", 32'(bus.avm_address), 32'h00C);
    chk("zw_busy", 32'(monitor_ready), 32'd0);
    cyc(0, 0, 0, '0, 0);
    chk("zw_done", 32'({bus.avm_read, monitor_ready}), 32'd1);
    chk("zw_mon", MonDReg, 32'h1234_5678);
    chk("zw_inc", 32'(bus.avm_address), 32'h010);

    // Write stalled for 5 cycles.
    n = 0;
    cyc(0, 1, 0, mk_b(32'hCAFE_F00D), 1);
    if (bus.avm_write) n++;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, '0, (i < 5));
      if (bus.avm_write) n++;
    end
    chk("sw_cycles", 32'(n), 32'd6);
    chk("sw_addr", 32'(bus.avm_address), 32'h014);
    chk("sw_err", 32'(monitor_error), 32'd0);

    // Read that times out.
    n = 0;
    bus.avm_readdata = 32'h0BAD_0BAD;
    cyc(0, 0, 1, '0, 1);
    if (bus.avm_read) n++;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, '0, 1);
      if (bus.avm_read) n++;
    end
    chk("to_cycles", 32'(n), 32'(TMO));
    chk("to_mon", MonDReg, 32'hDEAD_BEEF);
    chk("to_err", 32'(monitor_error), 32'd1);
    chk("to_addr", 32'(bus.avm_address), 32'h014);
    cyc(1, 0, 0, mk_a(10'h5, 0, 1), 0);
    chk("to_clr", 32'(monitor_error), 32'd0);

    // Address wrap across two read-next strobes.
    cyc(1, 0, 0, mk_a(10'h3FF, 0, 0), 0);
    bus.avm_readdata = 32'h1111_1111;
    cyc(0, 0, 1, '0, 0);
    chk("wr_a0", 32'(bus.avm_address), 32'hFFC);
    cyc(0, 0, 0, '0, 0);
    bus.avm_readdata = 32'h2222_2222;
    cyc(0, 0, 1, '0, 0);
    chk("wr_a1", 32'(bus.avm_address), 32'h000);
    cyc(0, 0, 0, '0, 0);
    chk("wr_mon", MonDReg, 32'h2222_2222);

    // Overrun: command strobe while a read is stalled.
    bus.avm_readdata = 32'h0BAD_F00D;
    cyc(0, 0, 1, '0, 1);
    cyc(1, 0, 0, mk_a(10'h0, 1, 0), 1);
    cyc(0, 0, 0, '0, 0);
    chk("ov_err", 32'(monitor_error), 32'd1);
    chk("ov_mon", MonDReg, 32'h0BAD_F00D);
    chk("ov_addr", 32'(bus.avm_address), 32'h008);
    cyc(0, 0, 0, '0, 0);

    // Priority: write strobe beats command strobe.
    cyc(1, 1, 0, mk_b(32'h5555_AAAA), 0);
    chk("pr_wr", 32'({bus.avm_write, bus.avm_read}), 32'd2);
    chk("pr_data", bus.avm_writedata, 32'h5555_AAAA);
    chk("pr_addr", 32'(bus.avm_address), 32'h008);
    chk("pr_err", 32'(monitor_error), 32'd1);
    cyc(0, 0, 0, '0, 0);
    chk("pr_inc", 32'(bus.avm_address), 32'h00C);

    // Asynchronous reset during a stalled write.
    cyc(0, 1, 0, mk_b(32'h7777_7777), 1);
    cyc(0, 0, 0, '0, 1);
    chk("mr_pre", 32'(bus.avm_write), 32'd1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("mr_write", 32'(bus.avm_write), 32'd0);
    chk("mr_ready", 32'(monitor_ready), 32'd1);
    chk("mr_mon", MonDReg, 32'h0);
    chk("mr_addr", 32'(bus.avm_address), 32'h0);
    cyc(0, 0, 0, '0, 0);
    reset = 1'b0;
    bus.avm_readdata = 32'h0000_00A5;
    cyc(0, 0, 1, '0, 0);
    chk("mr_rd_addr", 32'(bus.avm_address), 32'h0);
    cyc(0, 0, 0, '0, 0);
    chk("mr_rd_mon", MonDReg, 32'h0000_00A5);
    cyc(0, 0, 0, '0, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
